// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: default widths,
// memory wait length and the memory-wait FSM state encoding.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DEF      = 5;
    localparam int MEM_WAIT_CYCLES_DEF = 4;
    localparam int STALL_CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_WAIT = 2'd1,
        FSM_DONE = 2'd2
    } mem_fsm_e;

    // A source register collides with a writer unless the writer is idle or targets r0.
    function automatic logic src_hits(input logic [31:0] src,
                                      input logic [31:0] dest,
                                      input logic        writes);
        return writes && (dest != 32'd0) && (src == dest);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master: pipeline side (drives stage info, receives freeze/flush).
// slave : controller side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    logic [REG_ADDR_W-1:0]  id_src1;
    logic [REG_ADDR_W-1:0]  id_src2;
    logic                   id_two_src;
    logic [REG_ADDR_W-1:0]  exe_dest;
    logic                   exe_wb_en;
    logic                   exe_mem_read;
    logic [REG_ADDR_W-1:0]  mem_dest;
    logic                   mem_wb_en;
    logic                   mem_req;
    logic                   branch_taken;

    logic                   pc_freeze;
    logic                   if2id_freeze;
    logic                   if2id_flush;
    logic                   id2exe_freeze;
    logic                   id2exe_flush;
    logic                   back_freeze;
    logic                   mem_ready;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, mem_req, branch_taken,
        input  pc_freeze, if2id_freeze, if2id_flush, id2exe_freeze, id2exe_flush,
               back_freeze, mem_ready, stall_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, mem_req, branch_taken,
        output pc_freeze, if2id_freeze, if2id_flush, id2exe_freeze, id2exe_flush,
               back_freeze, mem_ready, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait.sv
// Data-memory wait sequencer: freezes the pipe for MEM_WAIT_CYCLES cycles per
// access, then raises mem_ready for one cycle.
//
//   state | meaning
//   IDLE  | no access in flight; a mem_req starts one (busy this same cycle)
//   WAIT  | access in flight; wait_cnt counts down to the terminal count of 1
//   DONE  | data valid (mem_ready); mem_req ignored, always back to IDLE
module mem_wait_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = MEM_WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req_i,
    output logic mem_busy_o,
    output logic mem_ready_o
);

    localparam logic [3:0] WAIT_INIT = (MEM_WAIT_CYCLES > 0) ? 4'(MEM_WAIT_CYCLES - 1) : 4'd0;
    localparam logic       HAS_WAIT  = (MEM_WAIT_CYCLES > 0);

    mem_fsm_e   state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    // State and down-counter registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FSM_IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state and busy/ready decode; outputs are held low while in reset.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_busy_o  = 1'b0;
        mem_ready_o = 1'b0;
        unique case (state_q)
            FSM_IDLE: begin
                if (HAS_WAIT) begin
                    if (mem_req_i) begin
                        mem_busy_o = 1'b1;
                        wait_cnt_d = WAIT_INIT;
                        state_d    = (WAIT_INIT == 4'd0) ? FSM_DONE : FSM_WAIT;
                    end
                end else begin
                    // Single-cycle memory: data is ready in the request cycle.
                    mem_ready_o = mem_req_i;
                end
            end
            FSM_WAIT: begin
                mem_busy_o = 1'b1;
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = FSM_DONE;
                end
            end
            FSM_DONE: begin
                mem_ready_o = 1'b1;
                state_d     = FSM_IDLE;
            end
            default: begin
                state_d = FSM_IDLE;
            end
        endcase
        if (rst) begin
            mem_busy_o  = 1'b0;
            mem_ready_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: combines the memory-wait freeze, load-use / RAW
// bubble insertion and taken-branch flush into the freeze/flush controls of
// the PC and all pipe registers, and counts PC-stall cycles (saturating).
// Build option HAZARD_FORWARDING_EN: when defined, only load-use stalls;
// otherwise any RAW against EXE or MEM stalls.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W      = REG_ADDR_W_DEF,
    parameter int MEM_WAIT_CYCLES = MEM_WAIT_CYCLES_DEF,
    parameter int STALL_CNT_W     = STALL_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   hz
);

    logic                   mem_busy;
    logic                   mem_ready;
    logic                   hazard_raw;
    logic                   hazard;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    mem_wait_fsm #(
        .MEM_WAIT_CYCLES (MEM_WAIT_CYCLES)
    ) u_mem_wait_fsm (
        .clk         (clk),
        .rst         (rst),
        .mem_req_i   (hz.mem_req),
        .mem_busy_o  (mem_busy),
        .mem_ready_o (mem_ready)
    );

    // Operand collision detection against the EXE (and, without forwarding, MEM) writers.
    always_comb begin
        logic exe_hit;
        logic mem_hit;
        exe_hit = src_hits(32'(hz.id_src1), 32'(hz.exe_dest), hz.exe_wb_en)
               || (hz.id_two_src && src_hits(32'(hz.id_src2), 32'(hz.exe_dest), hz.exe_wb_en));
        mem_hit = src_hits(32'(hz.id_src1), 32'(hz.mem_dest), hz.mem_wb_en)
               || (hz.id_two_src && src_hits(32'(hz.id_src2), 32'(hz.mem_dest), hz.mem_wb_en));
`ifdef HAZARD_FORWARDING_EN
        hazard_raw = hz.exe_mem_read && exe_hit;
`else
        hazard_raw = exe_hit || mem_hit;
`endif
        // A memory freeze already holds ID, so the bubble is not needed then.
        hazard = hazard_raw && !mem_busy;
    end

    // Freeze/flush decode: memory freeze dominates, then hazard, then branch.
    always_comb begin
        hz.pc_freeze     = mem_busy || hazard;
        hz.if2id_freeze  = mem_busy || hazard;
        hz.id2exe_freeze = mem_busy;
        hz.back_freeze   = mem_busy;
        hz.id2exe_flush  = hazard;
        hz.if2id_flush   = hz.branch_taken && !hazard && !mem_busy;
        hz.mem_ready     = mem_ready;
        hz.stall_cnt     = stall_cnt_q;
    end

    // Saturating count of PC-stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz.pc_freeze && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the freeze/flush inputs of all pipe registers (IF2ID, ID2EXE, EXE2MEM, MEM2WB) and the PC register.
- Combines three sources: load-use (RAW) hazard detection, taken-branch flush, and a multi-cycle data-memory wait FSM.
- Memory stall freezes the whole pipe. Hazard inserts a bubble into ID2EXE. Branch flushes IF2ID.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- MEM_WAIT_CYCLES, 4, freeze cycles per data-memory access; 0 = single-cycle memory (no FSM stall); legal range 0..15.
- STALL_CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_src1  in  REG_ADDR_W  source reg 1 of instruction in ID.
- id_src2  in  REG_ADDR_W  source reg 2 of instruction in ID.
- id_two_src  in  1  ID instruction reads id_src2.
- exe_dest  in  REG_ADDR_W  destination reg in EXE.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_read  in  1  EXE instruction is a load.
- mem_dest  in  REG_ADDR_W  destination reg in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- mem_req  in  1  MEM-stage instruction is a load or store.
- branch_taken  in  1  branch resolved taken in ID.
- pc_freeze  out  1  hold PC.
- if2id_freeze  out  1  freeze IF2ID.
- if2id_flush  out  1  flush IF2ID.
- id2exe_freeze  out  1  freeze ID2EXE.
- id2exe_flush  out  1  load a bubble into ID2EXE.
- back_freeze  out  1  freeze EXE2MEM and MEM2WB.
- mem_ready  out  1  memory data valid this cycle; MEM2WB latches it.
- stall_cnt  out  STALL_CNT_W  total stalled cycles since reset, saturating.

Behaviour:
- Registered state: fsm ∈ {IDLE, WAIT, DONE}, wait_cnt[3:0], stall_cnt.
- Reset: fsm=IDLE, wait_cnt=0, stall_cnt=0. With all inputs 0, every output is 0.
- Reset asserted mid-WAIT aborts the access immediately. Outputs drop combinationally, and no mem_ready is issued.
- mem_busy (combinational) = (fsm==IDLE && mem_req && MEM_WAIT_CYCLES>0) || fsm==WAIT.
- While mem_busy: pc_freeze, if2id_freeze, id2exe_freeze and back_freeze are all 1, and both flushes are 0. Freeze dominates flush.
- FSM transitions:
  - IDLE: on mem_req with MEM_WAIT_CYCLES>0, go to WAIT with wait_cnt=MEM_WAIT_CYCLES-1; if MEM_WAIT_CYCLES==1, go straight to DONE.
  - WAIT: wait_cnt decrements each cycle; when wait_cnt==1, go to DONE.
  - DONE: mem_ready=1, no freeze from the FSM, and mem_req is ignored (the same instruction is leaving MEM). Next state is always IDLE.
- Timing guarantee: an access gets exactly MEM_WAIT_CYCLES frozen cycles, then one mem_ready cycle.
- MEM_WAIT_CYCLES==0: the FSM stays in IDLE and mem_ready = mem_req combinationally.
- Back-to-back accesses: a new mem_req seen in IDLE on the cycle after DONE starts a new access. There is no idle gap beyond DONE.
- hazard (combinational, evaluated only when not mem_busy):
  - Base condition: exe_mem_read && exe_wb_en && exe_dest!=0 && (id_src1==exe_dest || (id_two_src && id_src2==exe_dest)).
  - Response: pc_freeze=1, if2id_freeze=1, id2exe_flush=1. EXE and later stages advance.
- Branch: if2id_flush = branch_taken && !hazard && !mem_busy. The branch outcome is invalid while its operands are hazarded.
- Simultaneous hazard and branch: hazard wins, and the branch re-evaluates the next cycle.
- Register 0 never creates a hazard.
- stall_cnt increments on every cycle where pc_freeze=1 and saturates at all-ones.
- All freeze/flush outputs are combinational from state and inputs. There is no extra latency.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: forwarding exists in the pipe, so only the load-use hazard above stalls.
- Undefined: hazard also fires on any RAW against EXE (exe_wb_en, any opcode) or MEM (mem_wb_en && mem_dest!=0) on id_src1, or on id_src2 when id_two_src. Responses are the same as the base hazard.

Decomposition:
- Shared defines file: REG_ADDR_W, the FSM state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), and the MEM_WAIT_CYCLES default.
- One sub-module: mem_wait_fsm. It owns fsm and wait_cnt and outputs mem_busy and mem_ready.
- Hazard and branch logic stay in pipe_hazard_ctrl.

Test Plan:
- Reset release: all outputs 0 and stall_cnt=0. Assert rst mid-WAIT: fsm returns to IDLE, no mem_ready follows.
- mem_req=1 held in IDLE, MEM_WAIT_CYCLES=4: back_freeze=1 for exactly 4 cycles, then mem_ready=1 for 1 cycle, then freeze drops; stall_cnt=4.
- Load-use: exe_mem_read=1, exe_wb_en=1, exe_dest=5, id_src1=5 → pc_freeze=1, if2id_freeze=1, id2exe_flush=1 for 1 cycle. Same stimulus with exe_dest=0 → no stall.
- branch_taken=1 with no hazard → if2id_flush=1. branch_taken=1 during the load-use case above → if2id_flush=0. branch_taken=1 during mem wait → if2id_flush=0 and freezes=1.
- Two consecutive memory accesses (mem_req high again after DONE): second stall starts immediately, two mem_ready pulses 5 cycles apart.
- Build without HAZARD_FORWARDING_EN: mem_wb_en=1, mem_dest=7, id_src2=7, id_two_src=1 → stall. With HAZARD_FORWARDING_EN defined → no stall.
